fft16_stage_sequencer: RTL and testbench

- Control FSM that sequences the 16-point radix-2 FFT datapath through its four butterfly stages for one frame at a time.
- Accepts a frame-start handshake and pulses the input-bank load. Steps the stage select and twiddle-stride outputs, waiting out the registered butterfly latency after each stage.
- Presents a result-valid/ready handshake to the downstream consumer.
- Sits between the frame buffer / input mux and the stage butterfly units. Contains no datapath arithmetic.

---
 rtl/fft16_stage_sequencer.sv | 97 +++++++++
 tb/tb_fft16_stage_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_stage_sequencer.sv
// Control sequencer for a 16-point radix-2 FFT: loads one frame, steps the
// butterfly stages while waiting out their latency, then hands the result on.
module fft16_stage_sequencer #(
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned STAGE_LAT  = 1,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             abort,
   output logic             load_en,
   output logic             stage_en,
   output logic [1:0]       stage_sel,
   output logic [1:0]       tw_shift,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);
   localparam int unsigned SEL_W = 2;
   localparam int unsigned LAT_W = 3;
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_STAGES - 1);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(STAGE_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STAGE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [LAT_W-1:0] wait_cnt;
   logic             handshake;

   assign handshake = (state == S_DONE) && result_ready && !abort;

   // Next-state decode; abort returns to IDLE from every state.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!abort && start_valid) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = abort ? S_IDLE : S_STAGE;
         S_STAGE: state_nxt = abort ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (abort)                       state_nxt = S_IDLE;
            else if (wait_cnt == '0)         state_nxt = (stage_sel == LAST_SEL) ? S_DONE : S_STAGE;
         end
         S_DONE:  if (abort || result_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         start_ready  <= 1'b1;
         load_en      <= 1'b0;
         stage_en     <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         stage_sel    <= '0;
         tw_shift     <= LAST_SEL;
         wait_cnt     <= '0;
         frame_cnt    <= '0;
      end else begin
         state        <= state_nxt;
         start_ready  <= (state_nxt == S_IDLE);
         load_en      <= (state_nxt == S_LOAD);
         stage_en     <= (state_nxt == S_STAGE);
         result_valid <= (state_nxt == S_DONE);
         busy         <= (state_nxt != S_IDLE);

         if (state_nxt == S_LOAD) begin
            stage_sel <= '0;
            tw_shift  <= LAST_SEL;
         end else if (state == S_WAIT && state_nxt == S_STAGE) begin
            stage_sel <= stage_sel + SEL_W'(1);
            tw_shift  <= tw_shift - SEL_W'(1);
         end

         if (state_nxt == S_STAGE)
            wait_cnt <= LAT_LOAD;
         else if (state == S_WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - LAT_W'(1);

         if (handshake)
            frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// Bench for fft16_stage_sequencer: three configurations driven side by side and
// compared every cycle against a cycle-offset model of the frame schedule.
module tb_fft16_stage_sequencer;
   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       sv [N];
   logic       ab [N];
   logic       rr [N];
   logic       sr [N];
   logic       le [N];
   logic       se [N];
   logic       rv [N];
   logic       bz [N];
   logic [1:0] sel [N];
   logic [1:0] tw [N];
   logic [7:0] fc0;
   logic [7:0] fc1;
   logic [1:0] fc2;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: mt = cycles since the accepting edge (-1 when idle)
   int mt [N];
   int mcnt [N];
   int msel [N];
   int mtw [N];

   fft16_stage_sequencer #(.NUM_STAGES(4), .STAGE_LAT(1), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr[0]), .abort(ab[0]),
      .load_en(le[0]), .stage_en(se[0]), .stage_sel(sel[0]), .tw_shift(tw[0]),
      .result_valid(rv[0]), .result_ready(rr[0]), .busy(bz[0]), .frame_cnt(fc0));

   fft16_stage_sequencer #(.NUM_STAGES(2), .STAGE_LAT(3), .CNT_W(8)) u_b (
      .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr[1]), .abort(ab[1]),
      .load_en(le[1]), .stage_en(se[1]), .stage_sel(sel[1]), .tw_shift(tw[1]),
      .result_valid(rv[1]), .result_ready(rr[1]), .busy(bz[1]), .frame_cnt(fc1));

   fft16_stage_sequencer #(.NUM_STAGES(4), .STAGE_LAT(1), .CNT_W(2)) u_c (
      .clk(clk), .rst(rst), .start_valid(sv[2]), .start_ready(sr[2]), .abort(ab[2]),
      .load_en(le[2]), .stage_en(se[2]), .stage_sel(sel[2]), .tw_shift(tw[2]),
      .result_valid(rv[2]), .result_ready(rr[2]), .busy(bz[2]), .frame_cnt(fc2));

   function automatic int ns_of(input int i);
      return (i == 1) ? 2 : 4;
   endfunction

   function automatic int lat_of(input int i);
      return (i == 1) ? 3 : 1;
   endfunction

   function automatic int cmod_of(input int i);
      return (i == 2) ? 4 : 256;
   endfunction

   // First DONE offset: LOAD at 1, then each stage takes 1 + latency cycles
   function automatic int tdone(input int i);
      return 2 + ns_of(i) * (1 + lat_of(i));
   endfunction

   function automatic logic [31:0] get_fc(input int i);
      case (i)
         0:       return 32'(fc0);
         1:       return 32'(fc1);
         default: return 32'(fc2);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int i);
      if (rst) begin
         mt[i]   = -1;
         mcnt[i] = 0;
         msel[i] = 0;
         mtw[i]  = ns_of(i) - 1;
      end else if (mt[i] < 0) begin
         if (!ab[i] && sv[i]) mt[i] = 1;
      end else if (ab[i]) begin
         mt[i] = -1;
      end else if (mt[i] >= tdone(i)) begin
         if (rr[i]) begin
            mcnt[i] = (mcnt[i] + 1) % cmod_of(i);
            mt[i]   = -1;
         end
      end else begin
         mt[i]++;
      end
      if (mt[i] == 1) begin
         msel[i] = 0;
         mtw[i]  = ns_of(i) - 1;
      end else if (mt[i] > 1 && mt[i] < tdone(i)) begin
         msel[i] = (mt[i] - 2) / (1 + lat_of(i));
         mtw[i]  = ns_of(i) - 1 - msel[i];
      end
   endtask

   task automatic check_dut(input int i);
      int t;
      int td;
      t  = mt[i];
      td = tdone(i);
      chk($sformatf("start_ready%0d", i),  32'(sr[i]), 32'(t < 0));
      chk($sformatf("busy%0d", i),         32'(bz[i]), 32'(t >= 0));
      chk($sformatf("load_en%0d", i),      32'(le[i]), 32'(t == 1));
      chk($sformatf("stage_en%0d", i),     32'(se[i]),
          32'(t > 1 && t < td && ((t - 2) % (1 + lat_of(i))) == 0));
      chk($sformatf("result_valid%0d", i), 32'(rv[i]), 32'(t >= td));
      chk($sformatf("stage_sel%0d", i),    32'(sel[i]), 32'(msel[i]));
      chk($sformatf("tw_shift%0d", i),     32'(tw[i]), 32'(mtw[i]));
      chk($sformatf("frame_cnt%0d", i),    get_fc(i), 32'(mcnt[i]));
   endtask

   task automatic step();
      @(posedge clk);
      for (int i = 0; i < N; i++) model_step(i);
      cyc++;
      #1;
      for (int i = 0; i < N; i++) check_dut(i);
   endtask

   initial begin
      int n;
      int first;
      int second;
      int ne;
      int se_at [4];
      int se_tw [4];

      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         sv[i] = 1'b0; ab[i] = 1'b0; rr[i] = 1'b0;
         mt[i] = -1; mcnt[i] = 0; msel[i] = 0; mtw[i] = ns_of(i) - 1;
      end
      for (int k = 0; k < 3; k++) step();
      rst = 1'b0;
      step();

      // Single frame on the default configuration
      sv[0] = 1'b1; rr[0] = 1'b1;
      step();
      sv[0] = 1'b0;
      n = 1;
      while (!rv[0] && n < 30) begin step(); n++; end
      chk("t1_latency", 32'(n), 32'd10);
      step();
      chk("t1_frame_cnt", get_fc(0), 32'd1);
      chk("t1_start_ready", 32'(sr[0]), 32'd1);

      // Downstream backpressure
      rr[0] = 1'b0; sv[0] = 1'b1;
      step();
      sv[0] = 1'b0;
      n = 1;
      while (!rv[0] && n < 30) begin step(); n++; end
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t2_hold_valid", 32'(rv[0]), 32'd1);
         chk("t2_hold_sel", 32'(sel[0]), 32'd3);
      end
      chk("t2_cnt_before", get_fc(0), 32'd1);
      rr[0] = 1'b1;
      step();
      chk("t2_cnt_after", get_fc(0), 32'd2);

      // Back-to-back frames with start_valid held
      sv[0] = 1'b1; first = -1; second = -1;
      for (int k = 0; k < 25; k++) begin
         step();
         if (le[0]) begin
            if (first < 0) first = cyc;
            else if (second < 0) second = cyc;
         end
      end
      sv[0] = 1'b0;
      chk("t3_load_gap", 32'(second - first), 32'd11);
      for (int k = 0; k < 30; k++) step();
      chk("t3_frame_cnt", get_fc(0), 32'd5);

      // Abort in the WAIT following stage 1
      sv[0] = 1'b1;
      step();
      sv[0] = 1'b0;
      n = 0;
      while (!(se[0] && sel[0] == 2'd1) && n < 20) begin step(); n++; end
      chk("t4_reach_stage1", 32'(n), 32'd3);
      step();
      ab[0] = 1'b1;
      step();
      ab[0] = 1'b0;
      chk("t4_busy", 32'(bz[0]), 32'd0);
      chk("t4_start_ready", 32'(sr[0]), 32'd1);
      for (int k = 0; k < 15; k++) begin
         step();
         chk("t4_no_valid", 32'(rv[0]), 32'd0);
         chk("t4_no_stage", 32'(se[0]), 32'd0);
      end
      chk("t4_cnt_kept", get_fc(0), 32'd5);
      sv[0] = 1'b1;
      step();
      sv[0] = 1'b0;
      n = 1;
      while (!rv[0] && n < 30) begin step(); n++; end
      chk("t4_rerun_latency", 32'(n), 32'd10);
      step();
      chk("t4_rerun_cnt", get_fc(0), 32'd6);

      // Two stages with a three-cycle butterfly latency
      sv[1] = 1'b1; rr[1] = 1'b1; ne = 0;
      step();
      sv[1] = 1'b0;
      n = 1;
      while (!rv[1] && n < 30) begin
         if (se[1] && ne < 4) begin se_at[ne] = n; se_tw[ne] = 32'(tw[1]); ne++; end
         step();
         n++;
      end
      chk("t5_latency", 32'(n), 32'd10);
      chk("t5_stage_count", 32'(ne), 32'd2);
      chk("t5_stage0_at", 32'(se_at[0]), 32'd2);
      chk("t5_stage1_at", 32'(se_at[1]), 32'd6);
      chk("t5_stage0_tw", 32'(se_tw[0]), 32'd1);
      chk("t5_stage1_tw", 32'(se_tw[1]), 32'd0);
      step();

      // Narrow counter wraps after four frames
      rr[2] = 1'b1;
      for (int f = 1; f <= 4; f++) begin
         sv[2] = 1'b1;
         step();
         sv[2] = 1'b0;
         n = 1;
         while (!rv[2] && n < 30) begin step(); n++; end
         step();
         chk($sformatf("t6_wrap%0d", f), get_fc(2), 32'(f % 4));
      end

      // Asynchronous reset while in WAIT
      sv[2] = 1'b1;
      step();
      sv[2] = 1'b0;
      step();
      step();
      chk("t6_busy_pre", 32'(bz[2]), 32'd1);
      rst = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("t6_rst_busy%0d", i), 32'(bz[i]), 32'd0);
         chk($sformatf("t6_rst_ready%0d", i), 32'(sr[i]), 32'd1);
         chk($sformatf("t6_rst_stage_en%0d", i), 32'(se[i]), 32'd0);
         chk($sformatf("t6_rst_cnt%0d", i), get_fc(i), 32'd0);
      end
      step();
      rst = 1'b0;
      step();

      // Randomized traffic on all three configurations
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) begin
            sv[i] = ($urandom % 2) == 1;
            ab[i] = ($urandom % 16) == 0;
            rr[i] = ($urandom % 10) < 6;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
